weight_fetch: RTL

Read-side sequencer for the three-channel weight ROM used by the image convolution datapath. It generates per-channel ROM enables and addresses and absorbs the ROM's one-cycle registered read latency. It presents the weights to the MAC array as a valid/ready stream of 3-channel tuples, one tuple per kernel tap, filter by filter. It sits between the ROM and the convolution engine and owns all ROM read scheduling and backpressure.

---
 rtl/weight_fetch.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/weight_fetch.sv
// Read-side sequencer for the three-channel weight ROM: schedules ROM reads,
// absorbs the one-cycle read latency and streams 3-channel weight tuples.
module weight_fetch #(
    parameter int unsigned ROM_ADDR_BITS = 10,
    parameter int unsigned ROM_WIDTH     = 16,
    parameter int unsigned KERNEL_SIZE   = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ROM_ADDR_BITS-1:0]            filter_count,
    input  logic [2:0]                          ch_mask,
    output logic                                busy,
    output logic                                done,
    output logic [2:0]                          rom_en,
    output logic [2:0][ROM_ADDR_BITS-1:0]       rom_addr,
    input  logic [2:0][ROM_WIDTH-1:0]           rom_data,
    output logic                                w_valid,
    input  logic                                w_ready,
    output logic [2:0][ROM_WIDTH-1:0]           w_data,
    output logic                                w_last_tap,
    output logic                                w_last
);

    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned PTR_BITS   = 2;
    localparam int unsigned CNT_BITS   = 2;
    localparam int unsigned TAP_BITS   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(KERNEL_SIZE - 1);

    typedef logic [NUM_CH-1:0][ROM_WIDTH-1:0] tuple_t;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t                   state_q, state_d;
    logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [TAP_BITS-1:0]      tap_q, tap_d;
    logic [ROM_ADDR_BITS-1:0] filt_q, filt_d;
    logic [ROM_ADDR_BITS-1:0] fcount_q, fcount_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic                     pending_q, pending_d;
    logic                     pend_last_tap_q, pend_last_tap_d;
    logic                     pend_last_q, pend_last_d;
    tuple_t                   fifo_data_q [FIFO_DEPTH];
    tuple_t                   fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    fifo_tap_q, fifo_tap_d;
    logic [FIFO_DEPTH-1:0]    fifo_last_q, fifo_last_d;
    logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]      count_q, count_d;

    logic issue;
    logic tap_wrap;
    logic last_issue;
    logic fifo_empty;
    logic pop;
    logic head_last;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    // A read may only be issued when it is guaranteed a FIFO slot on return.
    assign issue      = (state_q == FETCH) &&
                        ((3'(count_q) + 3'(pending_q)) < 3'(FIFO_DEPTH));
    assign tap_wrap   = (tap_q == LAST_TAP);
    assign last_issue = issue && tap_wrap && (filt_q == fcount_q - ROM_ADDR_BITS'(1));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && w_ready;
    assign head_last  = fifo_last_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (filter_count == '0) ? FIN : FETCH;
            FETCH: if (last_issue) state_d = DRAIN;
            DRAIN: if (pop && head_last) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rom_en     = issue ? mask_q : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rom_addr[i] = addr_q;
        end
        busy       = (state_q == FETCH) || (state_q == DRAIN);
        done       = (state_q == FIN);
        w_valid    = !fifo_empty;
        w_data     = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
        w_last_tap = !fifo_empty && fifo_tap_q[rd_ptr_q];
        w_last     = !fifo_empty && head_last;
    end

    // Run counters, in-flight read tracking and capture FIFO
    always_comb begin
        addr_d          = addr_q;
        tap_d           = tap_q;
        filt_d          = filt_q;
        fcount_d        = fcount_q;
        mask_d          = mask_q;
        pending_d       = issue;
        pend_last_tap_d = issue && tap_wrap;
        pend_last_d     = last_issue;
        fifo_data_d     = fifo_data_q;
        fifo_tap_d      = fifo_tap_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q + CNT_BITS'(pending_q) - CNT_BITS'(pop);

        if (state_q == IDLE && start) begin
            fcount_d = filter_count;
            mask_d   = ch_mask;
            addr_d   = '0;
            tap_d    = '0;
            filt_d   = '0;
        end

        if (issue) begin
            addr_d = addr_q + ROM_ADDR_BITS'(1);
            if (tap_wrap) begin
                tap_d  = '0;
                filt_d = filt_q + ROM_ADDR_BITS'(1);
            end else begin
                tap_d  = tap_q + TAP_BITS'(1);
            end
        end

        // Masked channels are stored as zero so the consumer never sees stale ROM output.
        if (pending_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fifo_data_d[wr_ptr_q][i] = mask_q[i] ? rom_data[i] : '0;
            end
            fifo_tap_d[wr_ptr_q]  = pend_last_tap_q;
            fifo_last_d[wr_ptr_q] = pend_last_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            tap_q           <= '0;
            filt_q          <= '0;
            fcount_q        <= '0;
            mask_q          <= '0;
            pending_q       <= 1'b0;
            pend_last_tap_q <= 1'b0;
            pend_last_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_tap_q      <= '0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            addr_q          <= addr_d;
            tap_q           <= tap_d;
            filt_q          <= filt_d;
            fcount_q        <= fcount_d;
            mask_q          <= mask_d;
            pending_q       <= pending_d;
            pend_last_tap_q <= pend_last_tap_d;
            pend_last_q     <= pend_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_tap_q      <= fifo_tap_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

endmodule
